mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_alu_decode.sv | 31 +++
 rtl/mc_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, funct codes,
// ALU operation codes and ALU decode classes.
package mc_ctrl_pkg;

   localparam int STATE_BITS = 4;

   typedef enum logic [STATE_BITS-1:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_R_EX, S_R_WB, S_I_EX, S_I_WB, S_BR, S_JMP, S_TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_NOP = 6'b000000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Which rule the ALU decoder applies in the current state.
   typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE} alu_cls_t;

   function automatic logic is_mem_wait(state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation decode: selects the ALU code from the state's ALU class,
// the opcode (immediate ops) and the funct field (R-type).
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] cls,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output logic [2:0] alu_operation
);

   always_comb begin
      alu_operation = ALU_ADD;
      case (cls)
         CLS_SUB:   alu_operation = ALU_SUB;
         CLS_RTYPE: begin
            case (func)
               FN_ADD:  alu_operation = ALU_ADD;
               FN_SUB:  alu_operation = ALU_SUB;
               FN_AND:  alu_operation = ALU_AND;
               FN_OR:   alu_operation = ALU_OR;
               FN_SLT:  alu_operation = ALU_SLT;
               default: alu_operation = ALU_AND;
            endcase
         end
         CLS_ITYPE: alu_operation = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
         default:   alu_operation = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout.
// Define MC_CONTROL_TRAP_EN to trap undecoded opcodes instead of retiring them as nops.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       data_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_operation,
   output logic       instr_done,
   output logic       bus_err
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   logic [STATE_W-1:0] state_q;
   state_t             state, state_nxt;
   logic [CNT_W-1:0]   wait_cnt;
   logic               timeout;
   logic [1:0]         alu_cls;

   assign state = state_t'(state_q[STATE_BITS-1:0]);

   // Timeout fires on the MEM_TIMEOUT-th consecutive non-ready cycle; a ready
   // in that same cycle takes priority.
   assign timeout = is_mem_wait(state) && !mem_ready && !rst &&
                    (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= STATE_W'(S_FETCH);
         wait_cnt <= '0;
      end else begin
         state_q <= STATE_W'(state_nxt);
         if (is_mem_wait(state) && !mem_ready && !timeout)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      data_src   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      bus_err    = 1'b0;
      alu_cls    = CLS_ADD;
      case (state)
         S_FETCH: begin
            mem_read  = !timeout;
            alu_src_b = 2'b01;
            // ir/pc loads are gated by rst so reset shows only the FETCH decode.
            if (mem_ready && !rst) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout) begin
               bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
               OP_ADDI, OP_ANDI: state_nxt = S_I_EX;
               OP_BEQ, OP_BNE:   state_nxt = S_BR;
               OP_J:             state_nxt = S_JMP;
               OP_RTYPE: begin
                  if (func != FN_NOP) begin
                     state_nxt = S_R_EX;
                  end else begin
                     state_nxt  = S_FETCH;
                     instr_done = 1'b1;
                  end
               end
               default: begin
`ifdef MC_CONTROL_TRAP_EN
                  state_nxt = S_TRAP;
`else
                  state_nxt  = S_FETCH;
                  instr_done = 1'b1;
`endif
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = !timeout;
            if (mem_ready) begin
               state_nxt = S_MEM_WB;
            end else if (timeout) begin
               bus_err   = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            data_src   = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = !timeout;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end else if (timeout) begin
               bus_err   = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_R_EX: begin
            alu_src_a = 1'b1;
            alu_cls   = CLS_RTYPE;
            state_nxt = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_I_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_cls   = CLS_ITYPE;
            state_nxt = S_I_WB;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_BR: begin
            alu_src_a  = 1'b1;
            alu_cls    = CLS_SUB;
            pc_src     = 2'b01;
            pc_write   = (opcode == OP_BNE) ? !zero : zero;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_JMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_FETCH;
      endcase
   end

   mc_alu_decode u_alu_decode (
      .cls           (alu_cls),
      .opcode        (opcode),
      .func          (func),
      .alu_operation (alu_operation)
   );

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each instruction pushes an expected retire
// record; a monitor accumulates control activity and checks it at instr_done/bus_err.
// Build with MC_CONTROL_TRAP_EN to exercise the trap path for illegal opcodes.
module tb_mc_control_unit;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic [5:0] func = 6'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_dst, reg_write, data_src, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_operation;
   logic       instr_done, bus_err;

   always #5 clk = ~clk;

   mc_control_unit #(.MEM_TIMEOUT(15), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .reg_write(reg_write), .data_src(data_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_operation(alu_operation), .instr_done(instr_done), .bus_err(bus_err)
   );

   typedef struct {
      bit       err;
      int       cycles, rw, pcw, irw, mr, mw, iod;
      bit       rd, ds;
      bit [7:0] alum;
      bit [1:0] psrc;
   } rec_t;

   rec_t  exp_q[$];
   string tag_q[$];
   int    n_chk = 0;
   int    n_fail = 0;

   function automatic void chk(string name, int act, int req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endfunction

   task automatic push(string tag, bit err, int cycles, int rw, bit rd, bit ds,
                       int pcw, int irw, int mr, int mw, int iod,
                       bit [7:0] alum, bit [1:0] psrc);
      rec_t r;
      r.err = err; r.cycles = cycles; r.rw = rw; r.rd = rd; r.ds = ds;
      r.pcw = pcw; r.irw = irw; r.mr = mr; r.mw = mw; r.iod = iod;
      r.alum = alum; r.psrc = psrc;
      exp_q.push_back(r);
      tag_q.push_back(tag);
   endtask

   // Monitor: accumulate activity since the last retire/error, compare on each event.
   initial begin
      rec_t  acc, e;
      string t;
      acc = '{default: 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            acc = '{default: 0};
         end else begin
            acc.cycles++;
            if (reg_write) begin
               acc.rw++;
               acc.rd = acc.rd | reg_dst;
               acc.ds = acc.ds | data_src;
            end
            if (pc_write) acc.pcw++;
            if (pc_write && !ir_write) acc.psrc = acc.psrc | pc_src;
            if (ir_write)  acc.irw++;
            if (mem_read)  acc.mr++;
            if (mem_write) acc.mw++;
            if (i_or_d)    acc.iod++;
            acc.alum[alu_operation] = 1'b1;
            if (instr_done || bus_err) begin
               acc.err = bus_err;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_event: got done=%0b err=%0b expected none",
                           instr_done, bus_err);
               end else begin
                  e = exp_q.pop_front();
                  t = tag_q.pop_front();
                  chk({t, ".bus_err"},   acc.err,    e.err);
                  chk({t, ".cycles"},    acc.cycles, e.cycles);
                  chk({t, ".reg_write"}, acc.rw,     e.rw);
                  chk({t, ".reg_dst"},   acc.rd,     e.rd);
                  chk({t, ".data_src"},  acc.ds,     e.ds);
                  chk({t, ".pc_write"},  acc.pcw,    e.pcw);
                  chk({t, ".ir_write"},  acc.irw,    e.irw);
                  chk({t, ".mem_read"},  acc.mr,     e.mr);
                  chk({t, ".mem_write"}, acc.mw,     e.mw);
                  chk({t, ".i_or_d"},    acc.iod,    e.iod);
                  chk({t, ".alu_ops"},   acc.alum,   e.alum);
                  chk({t, ".pc_src"},    acc.psrc,   e.psrc);
               end
               acc = '{default: 0};
            end
         end
      end
   end

   task automatic cyc(input logic r);
      mem_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
      opcode = op; func = fn; zero = z;
      repeat (n) cyc(1'b1);
   endtask

   // Hold rst across a negedge so the monitor drops partial activity.
   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst.mem_read",  mem_read, 1);
      chk("rst.alu_src_b", alu_src_b, 1);
      chk("rst.alu_op",    alu_operation, 2);
      chk("rst.ir_write",  ir_write, 0);
      chk("rst.pc_write",  pc_write, 0);
      chk("rst.others",    {mem_write, i_or_d, reg_write, reg_dst, data_src, alu_src_a,
                            pc_src, instr_done, bus_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      push("add",  0, 4, 1, 1, 0, 1, 1, 1, 0, 0, 8'h04, 2'b00); run(OP_RTYPE, FN_ADD, 0, 4);
      push("sub",  0, 4, 1, 1, 0, 1, 1, 1, 0, 0, 8'h44, 2'b00); run(OP_RTYPE, FN_SUB, 0, 4);
      push("slt",  0, 4, 1, 1, 0, 1, 1, 1, 0, 0, 8'h84, 2'b00); run(OP_RTYPE, FN_SLT, 0, 4);
      push("or",   0, 4, 1, 1, 0, 1, 1, 1, 0, 0, 8'h06, 2'b00); run(OP_RTYPE, FN_OR, 0, 4);
      push("rbad", 0, 4, 1, 1, 0, 1, 1, 1, 0, 0, 8'h05, 2'b00); run(OP_RTYPE, 6'b000111, 0, 4);

      push("lw", 0, 8, 1, 0, 1, 1, 1, 5, 0, 4, 8'h04, 2'b00);
      opcode = OP_LW; func = 6'b0;
      cyc(1); cyc(1); cyc(1); cyc(0); cyc(0); cyc(0); cyc(1); cyc(1);

      push("sw",    0, 4, 0, 0, 0, 1, 1, 1, 1, 1, 8'h04, 2'b00); run(OP_SW, 0, 0, 4);
      push("addi",  0, 4, 1, 0, 0, 1, 1, 1, 0, 0, 8'h04, 2'b00); run(OP_ADDI, 0, 0, 4);
      push("andi",  0, 4, 1, 0, 0, 1, 1, 1, 0, 0, 8'h05, 2'b00); run(OP_ANDI, 0, 0, 4);
      push("beq_t", 0, 3, 0, 0, 0, 2, 1, 1, 0, 0, 8'h44, 2'b01); run(OP_BEQ, 0, 1, 3);
      push("bne_z", 0, 3, 0, 0, 0, 1, 1, 1, 0, 0, 8'h44, 2'b00); run(OP_BNE, 0, 1, 3);
      push("bne_t", 0, 3, 0, 0, 0, 2, 1, 1, 0, 0, 8'h44, 2'b01); run(OP_BNE, 0, 0, 3);
      push("j",     0, 3, 0, 0, 0, 2, 1, 1, 0, 0, 8'h04, 2'b10); run(OP_J, 0, 0, 3);
      push("nop",   0, 2, 0, 0, 0, 1, 1, 1, 0, 0, 8'h04, 2'b00); run(OP_RTYPE, FN_NOP, 0, 2);

      push("fetch_to", 1, 15, 0, 0, 0, 0, 0, 14, 0, 0, 8'h04, 2'b00);
      repeat (15) cyc(0);

      push("fetch_edge", 0, 17, 0, 0, 0, 2, 1, 15, 0, 0, 8'h04, 2'b10);
      opcode = OP_J;
      repeat (14) cyc(0);
      repeat (3) cyc(1);

      push("sw_to", 1, 18, 0, 0, 0, 1, 1, 1, 14, 15, 8'h04, 2'b00);
      opcode = OP_SW;
      repeat (3) cyc(1);
      repeat (15) cyc(0);

`ifdef MC_CONTROL_TRAP_EN
      opcode = 6'b111111;
      repeat (3) cyc(1);
      for (int i = 0; i < 3; i++) begin
         chk("trap.writes", {pc_write, ir_write, reg_write, mem_write, mem_read, instr_done}, 0);
         cyc(1);
      end
      pulse_reset();
`else
      push("illegal", 0, 2, 0, 0, 0, 1, 1, 1, 0, 0, 8'h04, 2'b00);
      run(6'b111111, 0, 0, 2);
`endif

      opcode = OP_SW;
      repeat (3) cyc(1);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_wr.before", mem_write, 1);
      #2 rst = 1'b1;
      #1 chk("rst_wr.async", mem_write, 0);
      @(posedge clk); #1;
      chk("rst_wr.mem_write", mem_write, 0);
      chk("rst_wr.fetch", mem_read, 1);
      chk("rst_wr.i_or_d", i_or_d, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      push("add_after", 0, 4, 1, 1, 0, 1, 1, 1, 0, 0, 8'h04, 2'b00); run(OP_RTYPE, FN_ADD, 0, 4);

      opcode = OP_RTYPE; func = FN_NOP;
      cyc(1);
      chk("drain.pending", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
